axi_read_arbiter: RTL

Shares one AXI read slave (AR + R channels) between NumMasters requesting masters.
- Round-robin arbitration on AR; one outstanding burst at a time.
- The granted master owns the R channel until the beat carrying RLAST handshakes.
- Counts R beats against the latched ARLEN and flags burst-length protocol violations from the slave.

---
 rtl/axi_read_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read slave (AR + R) among NumMasters masters.
// One burst in flight at a time; R beats are counted against ARLEN to flag slave length errors.
module axi_read_arbiter #(
  parameter int BusWidth   = 32,
  parameter int TagBits    = 4,
  parameter int NumMasters = 2
) (
  input  logic                                         ACLK,
  input  logic                                         ARESETn,
  input  logic [NumMasters-1:0]                        M_ARVALID,
  output logic [NumMasters-1:0]                        M_ARREADY,
  input  logic [NumMasters*(TagBits+BusWidth+8)-1:0]   M_ARPAYLOAD,
  output logic [BusWidth-1:0]                          M_RDATA,
  output logic [TagBits-1:0]                           M_RID,
  output logic [1:0]                                   M_RRESP,
  output logic                                         M_RLAST,
  output logic [NumMasters-1:0]                        M_RVALID,
  input  logic [NumMasters-1:0]                        M_RREADY,
  output logic [TagBits-1:0]                           S_ARID,
  output logic [BusWidth-1:0]                          S_ARADDR,
  output logic [3:0]                                   S_ARLEN,
  output logic [1:0]                                   S_ARSIZE,
  output logic [1:0]                                   S_ARBURST,
  output logic                                         S_ARVALID,
  input  logic                                         S_ARREADY,
  input  logic [TagBits-1:0]                           S_RID,
  input  logic [BusWidth-1:0]                          S_RDATA,
  input  logic [1:0]                                   S_RRESP,
  input  logic                                         S_RLAST,
  input  logic                                         S_RVALID,
  output logic                                         S_RREADY,
  output logic [NumMasters-1:0]                        GRANT,
  output logic                                         LEN_ERR
);

  localparam int PayW = TagBits + BusWidth + 8;
  localparam int IdxW = $clog2(NumMasters);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                  state_reg, state_next;
  logic [IdxW-1:0]         ptr_reg;
  logic [IdxW-1:0]         gidx_reg;
  logic [NumMasters-1:0]   grant_reg;
  logic [TagBits-1:0]      s_arid_reg;
  logic [BusWidth-1:0]     s_araddr_reg;
  logic [3:0]              s_arlen_reg;
  logic [1:0]              s_arsize_reg;
  logic [1:0]              s_arburst_reg;
  logic                    s_arvalid_reg;
  logic [3:0]              cnt_reg;
  logic                    len_err_reg;

  logic [PayW-1:0]         pay [NumMasters];
  logic [IdxW-1:0]         win_idx;
  logic [IdxW-1:0]         cand_idx;
  logic [NumMasters-1:0]   win_onehot;
  logic                    found;
  logic                    ar_hs;
  logic                    s_ar_hs;
  logic                    r_hs;
  logic                    in_data;
  int                      cand;

  genvar gi;
  generate
    for (gi = 0; gi < NumMasters; gi++) begin : g_master
      assign pay[gi]        = M_ARPAYLOAD[gi*PayW +: PayW];
      assign win_onehot[gi] = (win_idx == IdxW'(gi));
      assign M_ARREADY[gi]  = ar_hs && win_onehot[gi];
      assign M_RVALID[gi]   = in_data && (gidx_reg == IdxW'(gi)) && S_RVALID;
    end
  endgenerate

  // First requester at or after the pointer, searching with wrap-around.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NumMasters; k++) begin
      cand = int'(ptr_reg) + k;
      if (cand >= NumMasters) cand = cand - NumMasters;
      cand_idx = IdxW'(cand);
      if (!found && M_ARVALID[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  // Reset gating keeps the combinational AR ready low while reset is held.
  assign ar_hs    = ARESETn && (state_reg == IDLE) && found;
  assign s_ar_hs  = s_arvalid_reg && S_ARREADY;
  assign in_data  = (state_reg == DATA);
  assign S_RREADY = in_data && M_RREADY[gidx_reg];
  assign r_hs     = in_data && S_RVALID && S_RREADY;

  assign M_RDATA   = S_RDATA;
  assign M_RID     = S_RID;
  assign M_RRESP   = S_RRESP;
  assign M_RLAST   = S_RLAST;

  assign S_ARID    = s_arid_reg;
  assign S_ARADDR  = s_araddr_reg;
  assign S_ARLEN   = s_arlen_reg;
  assign S_ARSIZE  = s_arsize_reg;
  assign S_ARBURST = s_arburst_reg;
  assign S_ARVALID = s_arvalid_reg;
  assign GRANT     = grant_reg;
  assign LEN_ERR   = len_err_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ar_hs) state_next = ADDR;
      ADDR:    if (s_ar_hs) state_next = DATA;
      DATA:    if (r_hs && S_RLAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ptr_reg       <= '0;
      gidx_reg      <= '0;
      grant_reg     <= '0;
      s_arid_reg    <= '0;
      s_araddr_reg  <= '0;
      s_arlen_reg   <= '0;
      s_arsize_reg  <= '0;
      s_arburst_reg <= '0;
      s_arvalid_reg <= 1'b0;
      cnt_reg       <= '0;
      len_err_reg   <= 1'b0;
    end else begin
      if (ar_hs) begin
        {s_arid_reg, s_araddr_reg, s_arlen_reg, s_arsize_reg, s_arburst_reg} <= pay[win_idx];
        s_arvalid_reg <= 1'b1;
        grant_reg     <= win_onehot;
        gidx_reg      <= win_idx;
        ptr_reg       <= (win_idx == IdxW'(NumMasters - 1)) ? '0 : win_idx + IdxW'(1);
      end
      if (s_ar_hs) begin
        s_arvalid_reg <= 1'b0;
        cnt_reg       <= s_arlen_reg;
      end
      if (r_hs) begin
        if (cnt_reg != 4'd0) cnt_reg <= cnt_reg - 4'd1;
        // Early last (count remaining) or late last (count exhausted, no RLAST).
        if (S_RLAST == (cnt_reg != 4'd0)) len_err_reg <= 1'b1;
        if (S_RLAST) grant_reg <= '0;
      end
    end
  end

endmodule
